// File: rtl/mux_serializer_16.sv
// mux_serializer_16: 16-bit word to serial stream via a 16:1 select with valid/ready on both sides.
// Define MUX_SER_PARITY_EN to append an even-parity beat after the 16 data beats.
module mux_serializer_16 #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        ser_ready,
   output logic        ser_valid,
   output logic        ser_out,
   output logic [3:0]  sel,
   output logic        ser_par,
   output logic        busy,
   output logic        done
);
`ifdef MUX_SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
   localparam state_e DATA_END = PARITY;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_e;
   localparam state_e DATA_END = IDLE;
`endif
   localparam logic [3:0] FIRST = MSB_FIRST ? 4'd15 : 4'd0;
   localparam logic [3:0] LAST = MSB_FIRST ? 4'd0 : 4'd15;
   state_e state_q, state_d;
   logic [15:0] word_q, word_d;
   logic [3:0] sel_q, sel_d;
   logic load, step;
   assign in_ready = rst_n & (state_q == IDLE);
   assign load = in_valid & in_ready;
   assign step = (state_q == SHIFT) & ser_ready;
   assign ser_valid = state_q != IDLE;
   assign busy = state_q != IDLE;
   assign sel = sel_q;
   always_comb begin
      word_d = load ? in_data : word_q;
      sel_d = load ? FIRST : (step && sel_q != LAST) ? (MSB_FIRST ? sel_q - 4'd1 : sel_q + 4'd1) : sel_q;
      case (state_q)
         IDLE: state_d = load ? SHIFT : IDLE;
         SHIFT: state_d = (ser_ready && sel_q == LAST) ? DATA_END : SHIFT;
`ifdef MUX_SER_PARITY_EN
         PARITY: state_d = ser_ready ? IDLE : PARITY;
`endif
         default: state_d = IDLE;
      endcase
   end
`ifdef MUX_SER_PARITY_EN
   assign ser_par = state_q == PARITY;
   assign ser_out = ((state_q == SHIFT) & word_q[sel_q]) | (ser_par & (^word_q));
   assign done = ser_ready & ser_par;
`else
   assign ser_par = 1'b0;
   assign ser_out = (state_q == SHIFT) & word_q[sel_q];
   assign done = ser_ready & (state_q == SHIFT) & (sel_q == LAST);
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q <= '0;
         sel_q <= '0;
      end else begin
         state_q <= state_d;
         word_q <= word_d;
         sel_q <= sel_d;
      end
   end
endmodule

// File: tb/tb_mux_serializer_16.sv
// tb_mux_serializer_16: drives an LSB-first and an MSB-first instance in lockstep against a beat-index model.
module tb_mux_serializer_16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic ser_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic a_in_ready, a_ser_valid, a_ser_out, a_ser_par, a_busy, a_done;
   logic b_in_ready, b_ser_valid, b_ser_out, b_ser_par, b_busy, b_done;
   logic [3:0] a_sel, b_sel;
   int n_chk = 0;
   int n_fail = 0;
`ifdef MUX_SER_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif
   always #5 clk = ~clk;

   mux_serializer_16 #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .ser_ready(ser_ready), .ser_valid(a_ser_valid), .ser_out(a_ser_out), .sel(a_sel),
      .ser_par(a_ser_par), .busy(a_busy), .done(a_done));
   mux_serializer_16 #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .ser_ready(ser_ready), .ser_valid(b_ser_valid), .ser_out(b_ser_out), .sel(b_sel),
      .ser_par(b_ser_par), .busy(b_busy), .done(b_done));

   // {ser_valid, busy, in_ready, ser_par, done, ser_out, sel}
   wire [9:0] obs_a = {a_ser_valid, a_busy, a_in_ready, a_ser_par, a_done, a_ser_out, a_sel};
   wire [9:0] obs_b = {b_ser_valid, b_busy, b_in_ready, b_ser_par, b_done, b_ser_out, b_sel};

   // Beat k of a word: data beats 0..15 then (optionally) the parity beat 16.
   task automatic send_word(input logic [15:0] w, input int stall_pct, input int stall_at,
                            input bit hold, input int abort_at);
      int k = 0;
      int sc = 0;
      logic [9:0] ea, eb;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = w;
      ser_ready = 1'($urandom_range(1));
      #1;
      n_chk += 2;
      if (obs_a[9:4] !== 6'b001000) begin
         n_fail++;
         $display("FAIL load_idle_lsb got %b want 001000", obs_a[9:4]);
      end
      if (obs_b[9:4] !== 6'b001000) begin
         n_fail++;
         $display("FAIL load_idle_msb got %b want 001000", obs_b[9:4]);
      end
      for (int cyc = 0; k < NB && cyc < 500; cyc++) begin
         @(negedge clk);
         in_valid = hold;
         in_data = hold ? 16'($urandom) : 16'h0;
         if (k == stall_at && sc < 3) begin
            ser_ready = 1'b0;
            sc++;
         end else ser_ready = ($urandom_range(99) >= stall_pct);
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            n_chk += 2;
            if (obs_a !== 10'h0) begin
               n_fail++;
               $display("FAIL abort_lsb got %b want 0", obs_a);
            end
            if (obs_b !== 10'h0) begin
               n_fail++;
               $display("FAIL abort_msb got %b want 0", obs_b);
            end
            return;
         end
         #1;
         ea = {3'b110, 1'(k == 16), 1'(ser_ready && k == NB - 1),
               (k < 16) ? w[k] : ^w, (k < 16) ? 4'(k) : 4'd15};
         eb = {3'b110, 1'(k == 16), 1'(ser_ready && k == NB - 1),
               (k < 16) ? w[15 - k] : ^w, (k < 16) ? 4'(15 - k) : 4'd0};
         n_chk += 2;
         if (obs_a !== ea) begin
            n_fail++;
            $display("FAIL beat_lsb w=%h k=%0d got %b want %b", w, k, obs_a, ea);
         end
         if (obs_b !== eb) begin
            n_fail++;
            $display("FAIL beat_msb w=%h k=%0d got %b want %b", w, k, obs_b, eb);
         end
         if (ser_ready) k++;
      end
      n_chk++;
      if (k < NB) begin
         n_fail++;
         $display("FAIL word_timeout w=%h got %0d beats want %0d", w, k, NB);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      ser_ready = 1'($urandom_range(1));
      #1;
      n_chk += 2;
      if (obs_a[9:4] !== 6'b001000) begin
         n_fail++;
         $display("FAIL idle_lsb got %b want 001000", obs_a[9:4]);
      end
      if (obs_b[9:4] !== 6'b001000) begin
         n_fail++;
         $display("FAIL idle_msb got %b want 001000", obs_b[9:4]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 16'($urandom);
      ser_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_chk += 2;
      if (obs_a !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_lsb got %b want 0", obs_a);
      end
      if (obs_b !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_msb got %b want 0", obs_b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_chk += 2;
      if (obs_a !== 10'b0010000000) begin
         n_fail++;
         $display("FAIL release_lsb got %b want 0010000000", obs_a);
      end
      if (obs_b !== 10'b0010000000) begin
         n_fail++;
         $display("FAIL release_msb got %b want 0010000000", obs_b);
      end
   endtask

   task automatic test_patterns();
      send_word(16'hAAAA, 0, -1, 1'b0, -1);
      send_word(16'h8001, 0, -1, 1'b0, -1);
      send_word(16'h0001, 0, -1, 1'b0, -1);
      idle();
   endtask

   task automatic test_stall();
      send_word(16'h00F0, 0, 5, 1'b0, -1);
      for (int i = 0; i < 6; i++) send_word(16'($urandom), 40, -1, 1'b0, -1);
      idle();
   endtask

   task automatic test_reset_mid_word();
      send_word(16'hFFFF, 0, -1, 1'b0, 7);
      @(negedge clk);
      #1;
      n_chk += 2;
      if (obs_a !== 10'h0) begin
         n_fail++;
         $display("FAIL held_reset_lsb got %b want 0", obs_a);
      end
      if (obs_b !== 10'h0) begin
         n_fail++;
         $display("FAIL held_reset_msb got %b want 0", obs_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk += 2;
      if (obs_a !== 10'b0010000000) begin
         n_fail++;
         $display("FAIL rerelease_lsb got %b want 0010000000", obs_a);
      end
      if (obs_b !== 10'b0010000000) begin
         n_fail++;
         $display("FAIL rerelease_msb got %b want 0010000000", obs_b);
      end
      send_word(16'h5A3C, 0, -1, 1'b0, -1);
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) send_word(16'($urandom), 0, -1, 1'b1, -1);
      send_word(16'hC3A5, 20, -1, 1'b1, -1);
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) send_word(16'($urandom), 30, int'($urandom_range(15)), 1'($urandom_range(1)), -1);
      idle();
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_stall();
      test_reset_mid_word();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_serializer_16.md
MUX_SERIALIZER_16 -- requirements
Module: mux_serializer_16

Interface
REQ-001 Parameter: MSB_FIRST, default 0; 0 = emit bit 0 first (sel 0->15), 1 = emit bit 15 first (sel 15->0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  16  parallel word, captured on load.
REQ-007 ser_ready  input  1  downstream accepts current serial beat.
REQ-008 ser_valid  output  1  ser_out holds a valid beat.
REQ-009 ser_out  output  1  serial data bit, equal to word[sel] on data beats.
REQ-010 sel  output  4  current 16:1 select index.
REQ-011 ser_par  output  1  high on the parity beat only (see Configuration).
REQ-012 busy  output  1  high while a word is in flight.
REQ-013 done  output  1  one-cycle pulse on the final accepted beat of a word.

Function
REQ-014 FSM states: IDLE, SHIFT, PARITY (PARITY only reachable with macro).
REQ-015 IDLE: in_ready=1, ser_valid=0, busy=0; load occurs when in_valid & in_ready at a clock edge.
REQ-016 Load: word register <= in_data; sel <= 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1); next state SHIFT.
REQ-017 SHIFT: ser_valid=1, busy=1, in_ready=0, ser_out=word[sel], ser_par=0.
REQ-018 Beat accepted when ser_valid & ser_ready at an edge; sel then steps +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-019 ser_ready=0: sel, word, ser_out held stable indefinitely; no beat lost or duplicated.
REQ-020 Last data beat (sel=15 or sel=0 per direction) accepted: without macro -> IDLE; with macro -> PARITY; sel does not wrap.
REQ-021 in_valid while busy is ignored; in_data not sampled outside IDLE.
REQ-022 Minimum word period with ser_ready held high: 17 cycles without macro (16 beats + 1 IDLE cycle), 18 with macro.
REQ-023 done asserted combinationally in the cycle the final beat is valid and ser_ready=1.
REQ-024 Latency: first beat valid in the cycle immediately after the load edge.

Reset
REQ-025 rst_n low: immediately force IDLE, word=0, sel=0, ser_valid=0, ser_out=0, ser_par=0, busy=0, done=0; in_ready=0 while rst_n low.
REQ-026 Reset mid-word discards remaining beats; no done pulse generated.
REQ-027 After rst_n deasserts, in_ready=1 in the first cycle; first load accepted at the next edge.

Configuration
REQ-028 Macro MUX_SER_PARITY_EN defined: after last data beat one PARITY beat with ser_valid=1, ser_par=1, ser_out = XOR of all 16 word bits (even parity), sel held at last value, subject to ser_ready stall; done fires on this beat.
REQ-029 Macro undefined: PARITY state and parity logic absent; ser_par tied 0; done fires on last data beat.

Verification
REQ-030 MSB_FIRST=0, load 16'hAAAA, ser_ready=1 -> ser_out 0,1,0,1,... over sel 0..15; done on sel=15 beat; in_ready=1 next cycle.
REQ-031 MSB_FIRST=1, load 16'h8001 -> ser_out 1, fourteen 0s, 1; sel 15 down to 0; done on sel=0 beat.
REQ-032 Load 16'h00F0, drop ser_ready for 3 cycles at sel=5 -> sel stays 5, ser_out stays 1, busy=1; resumes at sel=6; total 16 accepted beats.
REQ-033 Load 16'hFFFF, pulse rst_n low at sel=7 -> all outputs 0 in the same cycle, no done; after release in_ready=1, fresh word loads correctly.
REQ-034 With MUX_SER_PARITY_EN: 16'hAAAA -> 17th beat ser_par=1, ser_out=0; 16'h0001 -> ser_out=1; done on parity beat only.
REQ-035 Hold in_valid=1 with changing in_data during a word -> only the word present at load emitted; next word loads on first IDLE cycle.
